dist_seq_ctrl: RTL and testbench

Parametrised sequencer for the distance datapath, and the successor to the single-vector distance control unit. It walks NUM_OF_VECTORS vectors of VECTOR_WIDTH elements, LANES elements per fetch beat. For each beat it generates BRAM read addresses and drives the accumulator hard/soft-reset handshake. At the end of each vector it runs the square-root unit and writes the result back to BRAM. It sits between the host START/DONE interface and the pipe/accumulator/sqrt/BRAM blocks.

---
 rtl/dist_seq_ctrl_if.sv | 51 +++++
 rtl/dist_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dist_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dist_seq_ctrl_if.sv
// dist_seq_ctrl_if: bundle of the host START/DONE handshake and the
// accumulator / sqrt / BRAM control signals around the distance sequencer.
// The optional ABORT input exists only when DIST_SEQ_ABORT_EN is defined.
// master = the sequencer, slave = the surrounding host/datapath.
interface dist_seq_ctrl_if #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 10
);
  logic              START;
  logic [CNT_W-1:0]  NUM_OF_VECTORS;
  logic [CNT_W-1:0]  VECTOR_WIDTH;
  logic              RDY_Acc;
  logic              RDY_Sqrt;
`ifdef DIST_SEQ_ABORT_EN
  logic              ABORT;
`endif
  logic              EN_Acc;
  logic              RST_Acc;
  logic              PRE_Acc;
  logic              EN_Sqrt;
  logic [ADDR_W-1:0] ADDR_Bram;
  logic              RD_Bram;
  logic              WR_Bram;
  logic [CNT_W-1:0]  VEC_IDX;
  logic              BUSY;
  logic              DONE;

`ifdef DIST_SEQ_ABORT_EN
  modport master (
    input  START, NUM_OF_VECTORS, VECTOR_WIDTH, RDY_Acc, RDY_Sqrt, ABORT,
    output EN_Acc, RST_Acc, PRE_Acc, EN_Sqrt, ADDR_Bram, RD_Bram, WR_Bram,
           VEC_IDX, BUSY, DONE
  );
  modport slave (
    output START, NUM_OF_VECTORS, VECTOR_WIDTH, RDY_Acc, RDY_Sqrt, ABORT,
    input  EN_Acc, RST_Acc, PRE_Acc, EN_Sqrt, ADDR_Bram, RD_Bram, WR_Bram,
           VEC_IDX, BUSY, DONE
  );
`else
  modport master (
    input  START, NUM_OF_VECTORS, VECTOR_WIDTH, RDY_Acc, RDY_Sqrt,
    output EN_Acc, RST_Acc, PRE_Acc, EN_Sqrt, ADDR_Bram, RD_Bram, WR_Bram,
           VEC_IDX, BUSY, DONE
  );
  modport slave (
    output START, NUM_OF_VECTORS, VECTOR_WIDTH, RDY_Acc, RDY_Sqrt,
    input  EN_Acc, RST_Acc, PRE_Acc, EN_Sqrt, ADDR_Bram, RD_Bram, WR_Bram,
           VEC_IDX, BUSY, DONE
  );
`endif
endinterface

// File: rtl/dist_seq_ctrl.sv
// dist_seq_ctrl: multi-vector sequencer for the distance datapath.
// Walks NUM_OF_VECTORS vectors of VECTOR_WIDTH elements, LANES elements per
// fetch beat, issuing BRAM reads with the accumulator hard/soft reset
// handshake, then runs sqrt and writes each result to RES_BASE + vector index.
// Optional feature: define DIST_SEQ_ABORT_EN to add an ABORT input that
// cancels a run (no write, no DONE).
module dist_seq_ctrl #(
  parameter int CNT_W    = 8,
  parameter int ADDR_W   = 10,
  parameter int LANES    = 1,
  parameter int RES_BASE = 512
) (
  input logic             clk,
  input logic             rst,
  dist_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, HARD_RESET, WAIT_ACC, SOFT_RESET, SQRT, WRITE, FINISH
  } state_e;

  localparam logic [CNT_W-1:0]  ONE_C      = CNT_W'(1);
  localparam logic [CNT_W:0]    LANES_W_C  = (CNT_W+1)'(LANES);
  localparam logic [CNT_W:0]    ROUND_C    = (CNT_W+1)'(LANES - 1);
  localparam logic [ADDR_W-1:0] LANES_A_C  = ADDR_W'(LANES);
  localparam logic [ADDR_W-1:0] RES_BASE_C = ADDR_W'(RES_BASE);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  num_vec_q, num_vec_d;
  logic [CNT_W-1:0]  vec_w_q, vec_w_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  vec_idx_q, vec_idx_d;
  logic [ADDR_W-1:0] elem_base_q, elem_base_d;
  logic [ADDR_W-1:0] beat_addr_q, beat_addr_d;
  logic [CNT_W-1:0]  beats_calc;
  logic              abort;

  // Beats per vector, ceil(VECTOR_WIDTH/LANES); one extra bit so the rounding add cannot overflow.
  assign beats_calc = CNT_W'(({1'b0, bus.VECTOR_WIDTH} + ROUND_C) / LANES_W_C);

`ifdef DIST_SEQ_ABORT_EN
  assign abort = bus.ABORT;
`else
  assign abort = 1'b0;
`endif

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      num_vec_q   <= '0;
      vec_w_q     <= '0;
      beats_q     <= '0;
      beat_q      <= '0;
      vec_idx_q   <= '0;
      elem_base_q <= '0;
      beat_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      num_vec_q   <= num_vec_d;
      vec_w_q     <= vec_w_d;
      beats_q     <= beats_d;
      beat_q      <= beat_d;
      vec_idx_q   <= vec_idx_d;
      elem_base_q <= elem_base_d;
      beat_addr_q <= beat_addr_d;
    end
  end

  // Next-state and counter update; beat address advances by LANES so no multiplier is needed.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    num_vec_d   = num_vec_q;
    vec_w_d     = vec_w_q;
    beats_d     = beats_q;
    beat_d      = beat_q;
    vec_idx_d   = vec_idx_q;
    elem_base_d = elem_base_q;
    beat_addr_d = beat_addr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.START && !abort) begin
          if (bus.NUM_OF_VECTORS == '0 || bus.VECTOR_WIDTH == '0) begin
            state_d = FINISH;
          end else begin
            num_vec_d   = bus.NUM_OF_VECTORS;
            vec_w_d     = bus.VECTOR_WIDTH;
            beats_d     = beats_calc;
            beat_d      = '0;
            vec_idx_d   = '0;
            elem_base_d = '0;
            beat_addr_d = '0;
            state_d     = HARD_RESET;
          end
        end
      end
      HARD_RESET: state_d = WAIT_ACC;
      WAIT_ACC: begin
        if (bus.RDY_Acc) begin
          if (beat_q == beats_q - ONE_C) begin
            state_d = SQRT;
          end else begin
            beat_d      = beat_q + ONE_C;
            beat_addr_d = beat_addr_q + LANES_A_C;
            state_d     = SOFT_RESET;
          end
        end
      end
      SOFT_RESET: state_d = WAIT_ACC;
      SQRT: begin
        if (bus.RDY_Sqrt) state_d = WRITE;
      end
      WRITE: begin
        if (vec_idx_q == num_vec_q - ONE_C) begin
          state_d = FINISH;
        end else begin
          vec_idx_d   = vec_idx_q + ONE_C;
          elem_base_d = elem_base_q + ADDR_W'(vec_w_q);
          beat_addr_d = elem_base_q + ADDR_W'(vec_w_q);
          beat_d      = '0;
          state_d     = HARD_RESET;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end

  // Moore output decode from the registered state.
  always_comb begin
    bus.EN_Acc    = 1'b0;
    bus.RST_Acc   = 1'b0;
    bus.PRE_Acc   = 1'b0;
    bus.EN_Sqrt   = 1'b0;
    bus.ADDR_Bram = '0;
    bus.RD_Bram   = 1'b0;
    bus.WR_Bram   = 1'b0;
    bus.DONE      = 1'b0;
    bus.BUSY      = (state_q != IDLE);
    bus.VEC_IDX   = (state_q != IDLE) ? vec_idx_q : '0;
    unique case (state_q)
      HARD_RESET: begin
        bus.EN_Acc    = 1'b1;
        bus.RST_Acc   = 1'b1;
        bus.RD_Bram   = 1'b1;
        bus.ADDR_Bram = elem_base_q;
      end
      WAIT_ACC: bus.EN_Acc = 1'b1;
      SOFT_RESET: begin
        bus.EN_Acc    = 1'b1;
        bus.RST_Acc   = 1'b1;
        bus.PRE_Acc   = 1'b1;
        bus.RD_Bram   = 1'b1;
        bus.ADDR_Bram = beat_addr_q;
      end
      SQRT: begin
        bus.EN_Acc  = 1'b1;
        bus.EN_Sqrt = 1'b1;
      end
      WRITE: begin
        bus.WR_Bram   = 1'b1;
        bus.ADDR_Bram = RES_BASE_C + ADDR_W'(vec_idx_q);
      end
      FINISH:  bus.DONE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dist_seq_ctrl.sv
// tb_dist_seq_ctrl: self-checking bench for dist_seq_ctrl. Two instances
// (LANES=1 and LANES=2) share stimulus; sel picks the one under test.
// Expected read/write address streams and the DONE cycle come from a
// behavioural model built with plain arithmetic from the run parameters.
`timescale 1ns/1ps
module tb_dist_seq_ctrl;
  localparam int CNT_W    = 8;
  localparam int ADDR_W   = 10;
  localparam int RES_BASE = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, rdy_acc, rdy_sqrt, sel;
  logic [7:0] num_vec, vec_w;
  int         d_acc, d_sqrt;
  int         checks = 0;
  int         passed = 0;
  int         fails  = 0;

  always #5 clk = ~clk;

  dist_seq_ctrl_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus1 ();
  dist_seq_ctrl_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus2 ();

  assign bus1.START          = start & ~sel;
  assign bus2.START          = start & sel;
  assign bus1.NUM_OF_VECTORS = num_vec;
  assign bus2.NUM_OF_VECTORS = num_vec;
  assign bus1.VECTOR_WIDTH   = vec_w;
  assign bus2.VECTOR_WIDTH   = vec_w;
  assign bus1.RDY_Acc        = rdy_acc;
  assign bus2.RDY_Acc        = rdy_acc;
  assign bus1.RDY_Sqrt       = rdy_sqrt;
  assign bus2.RDY_Sqrt       = rdy_sqrt;
`ifdef DIST_SEQ_ABORT_EN
  logic abort;
  assign bus1.ABORT = abort & ~sel;
  assign bus2.ABORT = abort & sel;
`endif

  dist_seq_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .LANES(1), .RES_BASE(RES_BASE)) u_dut_l1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );
  dist_seq_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .LANES(2), .RES_BASE(RES_BASE)) u_dut_l2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  // Outputs of the instance under test.
  logic              a_en_acc, a_rst_acc, a_pre, a_en_sqrt, a_rd, a_wr, a_busy, a_done;
  logic [ADDR_W-1:0] a_addr;
  logic [CNT_W-1:0]  a_vec_idx;
  logic [25:0]       a_all;
  assign a_en_acc  = sel ? bus2.EN_Acc    : bus1.EN_Acc;
  assign a_rst_acc = sel ? bus2.RST_Acc   : bus1.RST_Acc;
  assign a_pre     = sel ? bus2.PRE_Acc   : bus1.PRE_Acc;
  assign a_en_sqrt = sel ? bus2.EN_Sqrt   : bus1.EN_Sqrt;
  assign a_rd      = sel ? bus2.RD_Bram   : bus1.RD_Bram;
  assign a_wr      = sel ? bus2.WR_Bram   : bus1.WR_Bram;
  assign a_busy    = sel ? bus2.BUSY      : bus1.BUSY;
  assign a_done    = sel ? bus2.DONE      : bus1.DONE;
  assign a_addr    = sel ? bus2.ADDR_Bram : bus1.ADDR_Bram;
  assign a_vec_idx = sel ? bus2.VEC_IDX   : bus1.VEC_IDX;
  assign a_all     = {a_busy, a_done, a_en_acc, a_rst_acc, a_pre, a_en_sqrt,
                      a_rd, a_wr, a_addr, a_vec_idx};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ready responder: in a wait state, ready rises after the configured stall;
  // outside it the ready lines carry random noise that must be ignored.
  initial begin : responder
    int wa, ws;
    wa = 0; ws = 0;
    rdy_acc = 1'b0; rdy_sqrt = 1'b0;
    forever begin
      @(negedge clk);
      if (a_en_acc && !a_rst_acc && !a_en_sqrt) begin
        rdy_acc = (wa >= d_acc);
        wa++;
      end else begin
        rdy_acc = 1'($urandom_range(0, 1));
        wa = 0;
      end
      if (a_en_sqrt) begin
        rdy_sqrt = (ws >= d_sqrt);
        ws++;
      end else begin
        rdy_sqrt = 1'($urandom_range(0, 1));
        ws = 0;
      end
    end
  end

  // One run of n vectors of w elements with da/ds stall cycles, checked against the model.
  task automatic run_job(input int n, input int w, input int da, input int ds, input bit extra);
    int q_rd[$];
    int q_wr[$];
    int lanes, nb, exp_done, exp_sq, n_rd, c, sq_cnt, rd_seen, wr_seen, e;
    bit got_done;
    lanes = sel ? 2 : 1;
    nb    = (w + lanes - 1) / lanes;
    if (n == 0 || w == 0) begin
      exp_done = 1;
      exp_sq   = 0;
    end else begin
      for (int v = 0; v < n; v++) begin
        for (int b = 0; b < nb; b++)
          q_rd.push_back(((b != 0) ? 65536 : 0) + ((v * w + b * lanes) % (1 << ADDR_W)));
        q_wr.push_back((RES_BASE + v) % (1 << ADDR_W));
      end
      exp_done = n * (nb * (2 + da) + 2 + ds) + 1;
      exp_sq   = n * (ds + 1);
    end
    n_rd    = q_rd.size();
    d_acc   = da;
    d_sqrt  = ds;
    sq_cnt  = 0;
    rd_seen = 0;
    wr_seen = 0;
    @(negedge clk);
    start = 1'b1; num_vec = 8'(n); vec_w = 8'(w);
    @(negedge clk);
    start = 1'b0; num_vec = 8'($urandom); vec_w = 8'($urandom);
    c = 1;
    got_done = 1'b0;
    while (!got_done && c <= exp_done + 40) begin
      check("rd_wr_exclusive", 32'(a_rd & a_wr), 32'd0);
      check("pre_needs_rst", 32'(a_pre & ~a_rst_acc), 32'd0);
      check("busy_in_run", 32'(a_busy), 32'd1);
      if (a_rd) begin
        rd_seen++;
        if (q_rd.size() != 0) begin
          e = q_rd.pop_front();
          check("rd_addr", 32'(a_addr), 32'(e % 65536));
          check("rd_pre", 32'(a_pre), 32'(e / 65536));
          check("rd_rst_acc", 32'(a_rst_acc), 32'd1);
          check("rd_en_acc", 32'(a_en_acc), 32'd1);
        end
      end
      if (a_wr) begin
        if (q_wr.size() != 0) begin
          e = q_wr.pop_front();
          check("wr_addr", 32'(a_addr), 32'(e));
          check("wr_vec_idx", 32'(a_vec_idx), 32'(wr_seen));
        end
        wr_seen++;
      end
      if (a_en_sqrt) sq_cnt++;
      if (a_done) begin
        got_done = 1'b1;
      end else begin
        if (extra && exp_done > 4 && c == 2) begin
          start = 1'b1; num_vec = 8'($urandom_range(1, 3)); vec_w = 8'($urandom_range(1, 3));
        end
        if (c == 3) start = 1'b0;
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    check("done_cycle", 32'(c), 32'(exp_done));
    check("rd_count", 32'(rd_seen), 32'(n_rd));
    check("wr_count", 32'(wr_seen), 32'((n == 0 || w == 0) ? 0 : n));
    check("sqrt_en_cycles", 32'(sq_cnt), 32'(exp_sq));
    @(negedge clk);
    check("idle_after_done", 32'({a_busy, a_done}), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  c;
    bit  found;
    rst = 1'b1; start = 1'b0; sel = 1'b0; num_vec = '0; vec_w = '0;
    d_acc = 0; d_sqrt = 0;
`ifdef DIST_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_outputs_l1", 32'({bus1.BUSY, bus1.DONE, bus1.EN_Acc, bus1.RST_Acc, bus1.PRE_Acc,
          bus1.EN_Sqrt, bus1.RD_Bram, bus1.WR_Bram, bus1.ADDR_Bram, bus1.VEC_IDX}), 32'd0);
    check("reset_outputs_l2", 32'({bus2.BUSY, bus2.DONE, bus2.EN_Acc, bus2.RST_Acc, bus2.PRE_Acc,
          bus2.EN_Sqrt, bus2.RD_Bram, bus2.WR_Bram, bus2.ADDR_Bram, bus2.VEC_IDX}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", 32'(a_all), 32'd0);

    // Directed runs: single vector, multi-lane, stalls, empty jobs, wrap, ignored START.
    sel = 1'b0; run_job(1, 4, 0, 0, 1'b0);
    sel = 1'b1; run_job(3, 5, 0, 0, 1'b1);
    sel = 1'b0; run_job(2, 4, 3, 5, 1'b1);
    sel = 1'b1; run_job(2, 5, 3, 5, 1'b0);
    sel = 1'b0; run_job(0, 7, 0, 0, 1'b0);
    sel = 1'b1; run_job(3, 0, 0, 0, 1'b0);
    sel = 1'b1; run_job(5, 250, 0, 0, 1'b0);

    // Randomised runs.
    for (int i = 0; i < 10; i++) begin
      sel = 1'($urandom_range(0, 1));
      run_job(int'($urandom_range(1, 5)), int'($urandom_range(1, 20)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
              1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while waiting on the accumulator in vector 1.
    sel = 1'b0; d_acc = 4; d_sqrt = 0;
    @(negedge clk);
    start = 1'b1; num_vec = 8'd3; vec_w = 8'd4;
    @(negedge clk);
    start = 1'b0;
    c = 1; found = 1'b0;
    while (!found && c < 200) begin
      if (a_vec_idx == 8'd1 && a_en_acc && !a_rst_acc && !a_en_sqrt) found = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    check("reached_vec1_wait", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_async_outputs", 32'(a_all), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_quiet", 32'({a_wr, a_done, a_busy}), 32'd0);
    end
    rst = 1'b0;
    run_job(1, 3, 0, 0, 1'b0);

`ifdef DIST_SEQ_ABORT_EN
    // Abort while waiting for sqrt: back to IDLE with no write and no DONE.
    sel = 1'b0; d_acc = 0; d_sqrt = 8;
    @(negedge clk);
    start = 1'b1; num_vec = 8'd2; vec_w = 8'd2;
    @(negedge clk);
    start = 1'b0;
    c = 1; found = 1'b0;
    while (!found && c < 100) begin
      if (a_en_sqrt) found = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    check("reached_sqrt", 32'(found), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_to_idle", 32'(a_busy), 32'd0);
    repeat (3) begin
      check("abort_quiet", 32'({a_wr, a_done, a_busy}), 32'd0);
      @(negedge clk);
    end
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
